// File: rtl/alu_pkg.sv
// Shared datapath ALU constants and saturation helpers.
package alu_pkg;

  localparam int ALU_WIDTH = 16;
  localparam int CLA_GROUP = 4;
  localparam int SAT_W_MAX = 64;

  // Largest positive two's-complement value of width w: {0, all 1s}
  function automatic logic [SAT_W_MAX-1:0] sat_max(input int w);
    logic [SAT_W_MAX-1:0] v;
    v = '0;
    for (int i = 0; i < SAT_W_MAX; i++) begin
      if (i < w - 1) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [SAT_W_MAX-1:0] sat_min(input int w);
    logic [SAT_W_MAX-1:0] v;
    v = '0;
    for (int i = 0; i < SAT_W_MAX; i++) begin
      if (i == w - 1) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry-lookahead slice; also exports group
// propagate/generate so a second lookahead level can be added later.
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] s,
  output logic             cout,
  output logic             p,
  output logic             g
);

  logic [GROUP-1:0] prop;
  logic [GROUP-1:0] gen;
  logic [GROUP:0]   carry;

  assign prop = a ^ b;
  assign gen  = a & b;

  always_comb begin
    carry    = '0;
    carry[0] = cin;
    for (int i = 0; i < GROUP; i++) begin
      carry[i+1] = gen[i] | (prop[i] & carry[i]);
    end
  end

  // Group generate is the carry-out the slice would produce with cin=0
  always_comb begin
    g = 1'b0;
    for (int i = 0; i < GROUP; i++) begin
      g = gen[i] | (prop[i] & g);
    end
  end

  assign p    = &prop;
  assign s    = prop ^ carry[GROUP-1:0];
  assign cout = carry[GROUP];

endmodule

// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor, one lookahead group per stage,
// with optional signed saturation and a valid/ready handshake.
module cla_addsub_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int GROUP = CLA_GROUP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovfl
);

  localparam int STAGES = WIDTH / GROUP;
  localparam int LAST   = STAGES - 1;
  localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(sat_min(WIDTH));

  if (GROUP < 1 || WIDTH < GROUP || (WIDTH % GROUP) != 0) begin : g_param_check
    $error("cla_addsub_pipe: WIDTH (%0d) must be a positive multiple of GROUP (%0d)",
           WIDTH, GROUP);
  end

  logic             adv;
  logic [WIDTH-1:0] bb_in;

  // Stage k's combinational inputs (cur_*) come from the port for k=0 and
  // from the st_* register of stage k-1 otherwise.
  logic             cur_v   [STAGES];
  logic [WIDTH-1:0] cur_a   [STAGES];
  logic [WIDTH-1:0] cur_b   [STAGES];
  logic [WIDTH-1:0] cur_s   [STAGES];
  logic             cur_c   [STAGES];
  logic             cur_sat [STAGES];
  logic [WIDTH-1:0] nxt_s   [STAGES];
  logic [GROUP-1:0] grp_s   [STAGES];
  logic             grp_c   [STAGES];
  logic             lookahead_unused_p [STAGES];
  logic             lookahead_unused_g [STAGES];

  logic             st_v   [STAGES];
  logic [WIDTH-1:0] st_a   [STAGES];
  logic [WIDTH-1:0] st_b   [STAGES];
  logic [WIDTH-1:0] st_s   [STAGES];
  logic             st_c   [STAGES];
  logic             st_sat [STAGES];

  logic [WIDTH-1:0] raw;
  logic             raw_ovfl;
  logic [WIDTH-1:0] result;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign bb_in    = sub ? ~b : b;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam logic [WIDTH-1:0] GMASK = WIDTH'({GROUP{1'b1}}) << (k * GROUP);

    if (k == 0) begin : g_first
      assign cur_v[k]   = in_valid;
      assign cur_a[k]   = a;
      assign cur_b[k]   = bb_in;
      assign cur_s[k]   = '0;
      assign cur_c[k]   = sub;
      assign cur_sat[k] = sat;
    end else begin : g_next
      assign cur_v[k]   = st_v[k-1];
      assign cur_a[k]   = st_a[k-1];
      assign cur_b[k]   = st_b[k-1];
      assign cur_s[k]   = st_s[k-1];
      assign cur_c[k]   = st_c[k-1];
      assign cur_sat[k] = st_sat[k-1];
    end

    cla_group #(.GROUP(GROUP)) u_group (
      .a    (cur_a[k][k*GROUP +: GROUP]),
      .b    (cur_b[k][k*GROUP +: GROUP]),
      .cin  (cur_c[k]),
      .s    (grp_s[k]),
      .cout (grp_c[k]),
      .p    (lookahead_unused_p[k]),
      .g    (lookahead_unused_g[k])
    );

    assign nxt_s[k] = (cur_s[k] & ~GMASK) | (WIDTH'(grp_s[k]) << (k * GROUP));
  end

  // Overflow is judged on a + bb + cin, which covers subtract without a special case
  assign raw      = nxt_s[LAST];
  assign raw_ovfl = (cur_a[LAST][WIDTH-1] == cur_b[LAST][WIDTH-1]) &&
                    (raw[WIDTH-1] != cur_a[LAST][WIDTH-1]);
  assign result   = (cur_sat[LAST] && raw_ovfl) ?
                    (cur_a[LAST][WIDTH-1] ? SAT_NEG : SAT_POS) : raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES - 1; k++) begin
        st_v[k] <= 1'b0;
      end
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovfl      <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES - 1; k++) begin
        st_v[k]   <= cur_v[k];
        st_a[k]   <= cur_a[k];
        st_b[k]   <= cur_b[k];
        st_s[k]   <= nxt_s[k];
        st_c[k]   <= grp_c[k];
        st_sat[k] <= cur_sat[k];
      end
      out_valid <= cur_v[LAST];
      // Result registers keep the last real beat through bubbles
      if (cur_v[LAST]) begin
        sum  <= result;
        cout <= grp_c[LAST];
        ovfl <= raw_ovfl;
      end
    end
  end

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Self-checking bench for cla_addsub_pipe (WIDTH=16, GROUP=4): directed
// corner beats, streaming, stalls, mid-stream reset and a random stream.
module tb_cla_addsub_pipe;

  localparam int WIDTH = 16;
  localparam int GROUP = 4;
  localparam int LAT   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              sub;
  logic              sat;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  sum;
  logic              cout;
  logic              ovfl;

  cla_addsub_pipe #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .sat       (sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovfl      (ovfl)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovfl;
  } res_t;

  res_t exp_q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   retired = 0;
  logic last_accept;
  logic last_in_ready;

  // Reference: exact signed arithmetic in int, unsigned compare for carry/borrow
  function automatic res_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic s, input logic st);
    int   sx, sy, exact;
    res_t r;
    sx     = int'($signed(x));
    sy     = int'($signed(y));
    exact  = s ? (sx - sy) : (sx + sy);
    r.ovfl = (exact > 32767) || (exact < -32768);
    r.cout = s ? (int'(x) >= int'(y)) : ((int'(x) + int'(y)) > 65535);
    r.sum  = exact[15:0];
    if (st && r.ovfl) r.sum = (exact > 0) ? 16'h7FFF : 16'h8000;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock: drive at the falling edge, retire/accept bookkeeping, advance
  task automatic applyStimulus(input logic v, input logic [15:0] x, input logic [15:0] y,
                               input logic s, input logic st, input logic ordy);
    in_valid  = v;
    a         = x;
    b         = y;
    sub       = s;
    sat       = st;
    out_ready = ordy;
    #1;
    last_in_ready = in_ready;
    last_accept   = v && in_ready;
    if (out_valid && out_ready) begin
      retired++;
      if (exp_q.size() == 0) checkOutput("unexpected_beat", 32'(exp_q.size()), 32'd1);
      else checkOutput("result", 32'({sum, cout, ovfl}), 32'(exp_q.pop_front()));
    end
    if (last_accept) exp_q.push_back(model(x, y, s, st));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic sendSingle(input string tag, input logic [15:0] x, input logic [15:0] y,
                            input logic s, input logic st);
    int lat;
    applyStimulus(1'b1, x, y, s, st, 1'b1);
    checkOutput({tag, "_accept"}, 32'(last_accept), 32'd1);
    lat = 1;
    while (!out_valid && lat < 20) begin
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      lat++;
    end
    checkOutput({tag, "_latency"}, 32'(lat), 32'(LAT));
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [15:0] vh;
    logic [15:0] bx, by;
    logic        bs, bt, ordy;
    res_t        held;
    int          nsent, nacc, n, stall_left;
    logic        post_checked;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; sat = 1'b0; out_ready = 1'b1;
    held = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_sum", 32'(sum), 32'd0);
    checkOutput("rst_cout", 32'(cout), 32'd0);
    checkOutput("rst_ovfl", 32'(ovfl), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

    $display("[TB] directed corner beats");
    sendSingle("pos_ovf_wrap", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    sendSingle("pos_ovf_sat",  16'h7FFF, 16'h0001, 1'b0, 1'b1);
    sendSingle("neg_ovf_sat",  16'h8000, 16'h0001, 1'b1, 1'b1);
    sendSingle("neg_ovf_wrap", 16'h8000, 16'h0001, 1'b1, 1'b0);
    sendSingle("sub_borrow",   16'h0005, 16'h0007, 1'b1, 1'b0);
    sendSingle("full_ripple",  16'hFFFF, 16'h0001, 1'b0, 1'b0);

    $display("[TB] back-to-back stream of 8");
    vh = '0; nacc = 0;
    for (int t = 0; t < 16; t++) begin
      if (out_valid) vh[t] = 1'b1;
      applyStimulus(t < 8, 16'(t), 16'(32'h1000 * t), 1'b0, 1'b0, 1'b1);
      if (last_accept) nacc++;
    end
    checkOutput("stream_accepts", 32'(nacc), 32'd8);
    checkOutput("stream_valid_cycles", 32'(vh), 32'h0FF0);

    $display("[TB] stream of 6 with a 3-cycle output stall");
    nsent = 0; n = 0; stall_left = 3; post_checked = 1'b0; retired = 0;
    bx = 16'($urandom); by = 16'($urandom); bs = 1'($urandom); bt = 1'($urandom);
    while ((nsent < 6 || exp_q.size() > 0) && n < 60) begin
      if (out_valid && stall_left == 3) begin
        held = {sum, cout, ovfl};
      end else if (stall_left < 3 && !post_checked) begin
        checkOutput("stall_hold", 32'({sum, cout, ovfl}), 32'(held));
        checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
        if (stall_left == 0) post_checked = 1'b1;
      end
      ordy = !(out_valid && stall_left > 0);
      applyStimulus(nsent < 6, bx, by, bs, bt, ordy);
      if (!ordy) begin
        checkOutput("stall_in_ready", 32'(last_in_ready), 32'd0);
        stall_left--;
      end
      if (last_accept) begin
        nsent++;
        bx = 16'($urandom); by = 16'($urandom); bs = 1'($urandom); bt = 1'($urandom);
      end
      n++;
    end
    checkOutput("stall_delivered", 32'(retired), 32'd6);
    checkOutput("stall_stalled_cycles", 32'(stall_left), 32'd0);

    $display("[TB] reset with beats in flight");
    for (int t = 0; t < 3; t++) begin
      applyStimulus(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    end
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_sum", 32'(sum), 32'd0);
    checkOutput("midrst_cout", 32'(cout), 32'd0);
    checkOutput("midrst_ovfl", 32'(ovfl), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    retired = 0;
    for (int t = 0; t < 8; t++) begin
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    end
    checkOutput("midrst_flushed", 32'(retired), 32'd0);
    sendSingle("post_rst", 16'h1234, 16'h0F0F, 1'b1, 1'b0);

    $display("[TB] random stream with random backpressure");
    nsent = 0; n = 0;
    bx = 16'($urandom); by = 16'($urandom); bs = 1'($urandom); bt = 1'($urandom);
    while (nsent < 40 && n < 400) begin
      applyStimulus(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, bx, by, bs, bt,
                    ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
      if (last_accept) begin
        nsent++;
        bx = 16'($urandom); by = 16'($urandom); bs = 1'($urandom); bt = 1'($urandom);
      end
      n++;
    end
    checkOutput("random_accepts", 32'(nsent), 32'd40);
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      n++;
    end
    checkOutput("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
